store_trace_buffer: RTL
=======================

# store_trace_buffer

Captures every data-memory store issued by the RISC-V core into a FIFO of {address, data} records. A debug reader drains the FIFO over a valid/ready port. The block sits downstream of the core's memory-stage outputs, in parallel with dmem, and is clocked by the same debug-gated clock. It also provides sticky pass/fail detection of the self-test signature store.

## Interface
Parameters:
- DEPTH, 16: number of FIFO entries; power of two, 2..256.
- PASS_ADDR, 32'd100: signature store address.
- PASS_DATA, 32'd25: signature value that means pass.

Ports:
- clk  in  1  debug-gated core clock (dbgclk at top level).
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- MemWriteM  in  1  store strobe from the core, post-BSR.
- DataAdrM  in  32  store address.
- WriteDataM  in  32  store data.
- clear  in  1  synchronous flush; same effect as reset on all state.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  reader accepts the head entry.
- rd_addr  out  32  head entry address.
- rd_data  out  32  head entry data.
- count  out  $clog2(DEPTH+1)  occupied entries.
- overflow  out  1  sticky: at least one store was dropped.
- drop_count  out  8  dropped stores; saturates at 255.
- success  out  1  sticky signature pass.
- fail  out  1  sticky signature fail.

## Operation
- Reset / clear: rd_valid=0, count=0, overflow=0, drop_count=0, success=0, fail=0. rd_addr and rd_data are 0 when empty. Pointers are 0.
- Push: a cycle with MemWriteM=1 and the FIFO not full writes {DataAdrM, WriteDataM} at the write pointer.
- Pop: a cycle with rd_valid=1 and rd_ready=1 advances the read pointer. rd_ready while empty is ignored.
- Push and pop in the same cycle:
  - count is unchanged.
  - When full, the pop frees a slot, so the push is accepted and nothing is dropped.
  - When empty, only the push happens. A pop needs rd_valid=1.
- Full with MemWriteM=1 and no pop: the store is dropped, overflow is set, and drop_count increments (saturating at 255). FIFO contents are unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty is decided by count, not by pointer comparison.
- Records keep strict store order. No coalescing or filtering.
- Signature check (see Configuration):
  - Evaluated on every MemWriteM=1 cycle, independent of FIFO acceptance.
  - DataAdrM==PASS_ADDR and WriteDataM==PASS_DATA sets success.
  - DataAdrM==PASS_ADDR and any other data sets fail.
  - First verdict wins: once success or fail is 1, both hold until reset or clear.
- reset or clear asserted during a push or pop: reset/clear wins; that cycle's push/pop is discarded.

## Timing
- Store in cycle N → rd_valid=1, rd_addr, rd_data and count all updated after posedge N+1. One-cycle latency.
- Pop in cycle N → next entry (or rd_valid=0) presented after posedge N+1.
- rd_addr, rd_data, rd_valid and count are driven from registers and FIFO storage only. They have no combinational path from rd_ready or MemWriteM.
- success and fail assert after the posedge that samples the signature store.
- clk may be stopped by the debug clock gate. All state holds while it is stopped.

## Configuration
- Macro: STORE_TRACE_CHECK_EN.
- Defined: signature check as described; PASS_ADDR and PASS_DATA are used.
- Undefined: the compare logic is omitted, and success and fail are tied to 0. FIFO behaviour is identical in both builds.

## Structure
- Package store_trace_pkg holds:
  - typedef trace_entry_t, a packed struct {logic [31:0] addr; logic [31:0] data;}.
  - localparam DROP_CNT_W = 8.
  - Default PASS_ADDR and PASS_DATA constants.
- One sub-module, trace_fifo: a synchronous FIFO parameterised on DEPTH and on the entry type. It has push/pop, full/empty and count, and clear.
- The top of store_trace_buffer holds drop accounting and the signature check.

## Test plan
- Reset, then 3 stores (0x10/0xA, 0x14/0xB, 0x18/0xC) with rd_ready=0 → count=3. Then rd_ready=1 → reads 0x10/0xA, 0x14/0xB, 0x18/0xC in order; rd_valid=0 after the third pop.
- DEPTH=16: 18 stores with rd_ready=0 → count=16, overflow=1, drop_count=2. Draining returns the first 16 stores.
- FIFO full, then a store and rd_ready=1 in the same cycle → count stays 16, drop_count unchanged, and the new record is last out.
- Store 100/25, then store 100/7 → success=1 and fail=0, held. After reset: store 100/7 → fail=1, success=0.
- Build without STORE_TRACE_CHECK_EN: store 100/25 → success=0, fail=0, and the record still appears in the FIFO.
- Pulse clear with 5 entries queued while a store and a pop are in flight → next cycle count=0, rd_valid=0, overflow=0, drop_count=0. Run 300 drops → drop_count saturates at 255.

Source files
------------

// File: rtl/store_trace_pkg.sv
// rtl/store_trace_pkg.sv - shared types and constants for the store trace buffer
package store_trace_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    localparam int DROP_CNT_W = 8;

    localparam logic [31:0] DEFAULT_PASS_ADDR = 32'd100;
    localparam logic [31:0] DEFAULT_PASS_DATA = 32'd25;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous count-tracked FIFO with flush, generic entry type
module trace_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [63:0]
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  entry_t                       push_entry,
    input  logic                         pop,
    output entry_t                       head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             flush;
    logic             do_pop;
    logic             do_push;

    // Occupancy decides full/empty so pointer equality is never ambiguous.
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign flush   = reset || clear;
    // A pop while full frees the slot the simultaneous push lands in.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // Head reads as zero when empty so the reader never sees stale records.
    assign head = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are not reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/store_trace_buffer.sv
// rtl/store_trace_buffer.sv - store capture FIFO with drop accounting; signature check under STORE_TRACE_CHECK_EN
module store_trace_buffer
    import store_trace_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] PASS_ADDR = DEFAULT_PASS_ADDR,
    parameter logic [31:0] PASS_DATA = DEFAULT_PASS_DATA
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWriteM,
    input  logic [31:0]                  DataAdrM,
    input  logic [31:0]                  WriteDataM,
    input  logic                         clear,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [31:0]                  rd_addr,
    output logic [31:0]                  rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic [7:0]                   drop_count,
    output logic                         success,
    output logic                         fail
);

    trace_entry_t store_entry;
    trace_entry_t head;
    logic         full;
    logic         empty;
    logic         drop;

    assign store_entry.addr = DataAdrM;
    assign store_entry.data = WriteDataM;

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (trace_entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .push       (MemWriteM),
        .push_entry (store_entry),
        .pop        (rd_ready),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    assign rd_valid = !empty;
    assign rd_addr  = head.addr;
    assign rd_data  = head.data;

    // A full FIFO is never empty, so a ready reader always frees a slot.
    assign drop = MemWriteM && full && !rd_ready;

    // Sticky overflow flag and saturating count of dropped stores.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {DROP_CNT_W{1'b1}}) begin
                drop_count <= drop_count + DROP_CNT_W'(1);
            end
        end
    end

`ifdef STORE_TRACE_CHECK_EN
    // First signature store decides the verdict; later ones are ignored.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            success <= 1'b0;
            fail    <= 1'b0;
        end else if (MemWriteM && !success && !fail && DataAdrM == PASS_ADDR) begin
            success <= (WriteDataM == PASS_DATA);
            fail    <= (WriteDataM != PASS_DATA);
        end
    end
`else
    logic unused_sig_params;
    assign unused_sig_params = ^{PASS_ADDR, PASS_DATA};
    assign success = 1'b0;
    assign fail    = 1'b0;
`endif

endmodule
